// File: rtl/portgroup_rx_fifo.sv
// Multi-channel receive port group: per-channel FWFT FIFOs with backpressure or drop mode.
// Optional per-channel 8-bit drop counters when PORTGROUP_RX_OVFCNT_EN is defined.
module portgroup_rx_fifo #(
  parameter int width_p = 8,
  parameter int chan_p  = 2,
  parameter int depth_p = 4,
  parameter int mode_p  = 0
) (
  input  logic                                   main_clk_i,
  input  logic                                   main_rst_i,
  input  logic                                   regf_ctrl_ena_rval_i,
  input  logic                                   rx_valid_i,
  output logic                                   rx_ready_o,
  input  logic [$clog2(chan_p)-1:0]              rx_chan_i,
  input  logic [width_p-1:0]                     rx_data_i,
  output logic [chan_p*width_p-1:0]              regf_rx_data_rbus_o,
  input  logic [chan_p-1:0]                      regf_rx_data_rd_i,
  output logic [chan_p*$clog2(depth_p+1)-1:0]    regf_rx_level_rbus_o,
  output logic [chan_p-1:0]                      regf_rx_ovf_rbus_o,
`ifdef PORTGROUP_RX_OVFCNT_EN
  output logic [chan_p*8-1:0]                    regf_rx_ovfcnt_rbus_o,
`endif
  input  logic [chan_p-1:0]                      regf_rx_ovf_clr_i
);

  localparam int cw = $clog2(chan_p);
  localparam int lw = $clog2(depth_p + 1);
  localparam int pw = $clog2(depth_p);

  logic [width_p-1:0] mem [chan_p][depth_p];
  logic [pw-1:0]      rd_ptr [chan_p];
  logic [pw-1:0]      wr_ptr [chan_p];
  logic [lw-1:0]      level  [chan_p];
  logic [chan_p-1:0]  ovf;
  logic [chan_p-1:0]  full, empty, sel, push, pop, drop;
  logic               in_range, sel_full, accept;

  // Handshake: a word transfers on a cycle where rx_valid_i and rx_ready_o are both high;
  // ready never looks at valid, and in drop mode a transferred word aimed at a full FIFO is discarded.
  always_comb begin
    full     = '0;
    empty    = '0;
    sel      = '0;
    sel_full = 1'b0;
    in_range = ({1'b0, rx_chan_i} < (cw + 1)'(chan_p));
    for (int c = 0; c < chan_p; c++) begin
      full[c]  = (level[c] == lw'(depth_p));
      empty[c] = (level[c] == '0);
      sel[c]   = (rx_chan_i == cw'(c));
      if (sel[c]) sel_full = full[c];
    end
    if (mode_p == 0)
      rx_ready_o = !main_rst_i & regf_ctrl_ena_rval_i & in_range & !sel_full;
    else
      rx_ready_o = !main_rst_i & regf_ctrl_ena_rval_i & in_range;
    accept = rx_valid_i & rx_ready_o;
    push   = '0;
    pop    = '0;
    drop   = '0;
    for (int c = 0; c < chan_p; c++) begin
      push[c] = accept & sel[c] & !full[c];
      drop[c] = accept & sel[c] & full[c] & (mode_p != 0);
      pop[c]  = regf_rx_data_rd_i[c] & !empty[c];
    end
  end

  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) begin
      for (int c = 0; c < chan_p; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        level[c]  <= '0;
      end
      ovf <= '0;
    end else begin
      for (int c = 0; c < chan_p; c++) begin
        // Disabling flushes contents but leaves overflow history untouched.
        if (!regf_ctrl_ena_rval_i) begin
          rd_ptr[c] <= '0;
          wr_ptr[c] <= '0;
          level[c]  <= '0;
        end else begin
          if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
          if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
          if (push[c] && !pop[c])      level[c] <= level[c] + 1'b1;
          else if (!push[c] && pop[c]) level[c] <= level[c] - 1'b1;
        end
        if (drop[c])                      ovf[c] <= 1'b1;
        else if (regf_rx_ovf_clr_i[c])    ovf[c] <= 1'b0;
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the level is zero.
  always_ff @(posedge main_clk_i) begin
    for (int c = 0; c < chan_p; c++)
      if (push[c]) mem[c][wr_ptr[c]] <= rx_data_i;
  end

  always_comb begin
    regf_rx_data_rbus_o  = '0;
    regf_rx_level_rbus_o = '0;
    for (int c = 0; c < chan_p; c++) begin
      regf_rx_data_rbus_o[c*width_p +: width_p] = empty[c] ? '0 : mem[c][rd_ptr[c]];
      regf_rx_level_rbus_o[c*lw +: lw]          = level[c];
    end
    regf_rx_ovf_rbus_o = ovf;
  end

`ifdef PORTGROUP_RX_OVFCNT_EN
  logic [7:0] ovf_cnt [chan_p];

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) begin
      for (int c = 0; c < chan_p; c++) ovf_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < chan_p; c++) begin
        if (drop[c]) begin
          if (regf_rx_ovf_clr_i[c])       ovf_cnt[c] <= 8'd1;
          else if (ovf_cnt[c] != 8'hff)   ovf_cnt[c] <= ovf_cnt[c] + 8'd1;
        end else if (regf_rx_ovf_clr_i[c]) begin
          ovf_cnt[c] <= '0;
        end
      end
    end
  end

  always_comb begin
    regf_rx_ovfcnt_rbus_o = '0;
    for (int c = 0; c < chan_p; c++)
      regf_rx_ovfcnt_rbus_o[c*8 +: 8] = ovf_cnt[c];
  end
`endif

endmodule

// File: tb/tb_portgroup_rx_fifo.sv
// Directed bench for portgroup_rx_fifo: one backpressure-mode and one drop-mode instance
// share stimulus; drop counters are checked when PORTGROUP_RX_OVFCNT_EN is defined.
module tb_portgroup_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       vld = 1'b0;
  logic [0:0] chan = '0;
  logic [7:0] dat = '0;
  logic [1:0] rd = '0;
  logic [1:0] clr = '0;

  logic        rdy0, rdy1;
  logic [15:0] data0, data1;
  logic [5:0]  lvl0, lvl1;
  logic [1:0]  ovf0, ovf1;
`ifdef PORTGROUP_RX_OVFCNT_EN
  logic [15:0] cnt0, cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  portgroup_rx_fifo #(.width_p(8), .chan_p(2), .depth_p(4), .mode_p(0)) u_dut0 (
    .main_clk_i(clk), .main_rst_i(rst), .regf_ctrl_ena_rval_i(ena),
    .rx_valid_i(vld), .rx_ready_o(rdy0), .rx_chan_i(chan), .rx_data_i(dat),
    .regf_rx_data_rbus_o(data0), .regf_rx_data_rd_i(rd),
    .regf_rx_level_rbus_o(lvl0), .regf_rx_ovf_rbus_o(ovf0),
`ifdef PORTGROUP_RX_OVFCNT_EN
    .regf_rx_ovfcnt_rbus_o(cnt0),
`endif
    .regf_rx_ovf_clr_i(clr)
  );

  portgroup_rx_fifo #(.width_p(8), .chan_p(2), .depth_p(4), .mode_p(1)) u_dut1 (
    .main_clk_i(clk), .main_rst_i(rst), .regf_ctrl_ena_rval_i(ena),
    .rx_valid_i(vld), .rx_ready_o(rdy1), .rx_chan_i(chan), .rx_data_i(dat),
    .regf_rx_data_rbus_o(data1), .regf_rx_data_rd_i(rd),
    .regf_rx_level_rbus_o(lvl1), .regf_rx_ovf_rbus_o(ovf1),
`ifdef PORTGROUP_RX_OVFCNT_EN
    .regf_rx_ovfcnt_rbus_o(cnt1),
`endif
    .regf_rx_ovf_clr_i(clr)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] head(input logic [15:0] bus, input int c);
    return bus[c*8 +: 8];
  endfunction

  function automatic logic [2:0] lvl(input logic [5:0] bus, input int c);
    return bus[c*3 +: 3];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic c, input logic [7:0] d, input logic [1:0] r);
    vld  = v;
    chan = c;
    dat  = d;
    rd   = r;
  endtask

  initial begin
    // reset state, with enable and valid already high
    ena = 1'b1;
    drive(1'b1, 1'b0, 8'hEE, 2'b00);
    #1;
    check("rst_rdy0", rdy0, 0);
    check("rst_rdy1", rdy1, 0);
    check("rst_data0", data0, 0);
    check("rst_lvl0", lvl0, 0);
    check("rst_ovf1", ovf1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vld = 1'b0;
    tick();

    // first push: head visible one cycle after acceptance
    drive(1'b1, 1'b0, 8'h11, 2'b00);
    #1;
    check("t1_rdy0", rdy0, 1);
    check("t1_head_before", head(data0, 0), 8'h00);
    tick();
    drive(1'b0, 1'b0, 8'h00, 2'b00);
    #1;
    check("t1_head0", head(data0, 0), 8'h11);
    check("t1_lvl0", lvl(lvl0, 0), 1);
    check("t1_head1", head(data0, 1), 8'h00);

    // fill channel 1, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 8'hA0 + 8'(i), 2'b00);
      exp_q.push_back(8'hA0 + 8'(i));
      tick();
    end
    drive(1'b0, 1'b1, 8'h00, 2'b00);
    #1;
    check("t2_lvl_full", lvl(lvl0, 1), 4);
    check("t2_rdy0_full", rdy0, 0);
    check("t2_rdy1_drop_mode", rdy1, 1);
    chan = 1'b0;
    #1;
    check("t2_rdy0_ch0", rdy0, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'h00, 2'b10);
      #1;
      if (i == 0) check("t2_no_bypass", rdy0, 0);
      check("t2_pop_head", head(data0, 1), exp_q.pop_front());
      tick();
    end
    drive(1'b0, 1'b1, 8'h00, 2'b10);
    #1;
    check("t2_lvl_empty", lvl(lvl0, 1), 0);
    check("t2_head_empty", head(data0, 1), 8'h00);
    tick();
    drive(1'b0, 1'b0, 8'h00, 2'b00);
    #1;
    check("t2_pop_empty_lvl", lvl(lvl1, 1), 0);
    check("t2_pop_empty_ovf", ovf1, 0);

    // simultaneous push/pop at level 2 with pointer wrap
    exp_q.push_back(8'h11);
    drive(1'b1, 1'b0, 8'h22, 2'b00);
    exp_q.push_back(8'h22);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 8'h50 + 8'(i), 2'b01);
      #1;
      check("t3_head", head(data0, 0), exp_q.pop_front());
      exp_q.push_back(8'h50 + 8'(i));
      tick();
      #1;
      check("t3_lvl", lvl(lvl0, 0), 2);
    end
    drive(1'b0, 1'b0, 8'h00, 2'b00);
    #1;
    check("t3_head_after", head(data0, 0), exp_q[0]);

    // fill channel 0, then overflow in drop mode
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 8'h60 + 8'(i), 2'b00);
      tick();
    end
    drive(1'b1, 1'b0, 8'h77, 2'b00);
    #1;
    check("t4_rdy0_bp", rdy0, 0);
    check("t4_rdy1_drop", rdy1, 1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 2'b00);
    #1;
    check("t4_ovf1", ovf1, 2'b01);
    check("t4_ovf0_never", ovf0, 2'b00);
    check("t4_lvl1", lvl(lvl1, 0), 4);
    check("t4_head1_intact", head(data1, 0), 8'h54);
    check("t4_lvl0", lvl(lvl0, 0), 4);
`ifdef PORTGROUP_RX_OVFCNT_EN
    check("t4_cnt1", cnt1[7:0], 1);
    check("t4_cnt0", cnt0, 0);
    drive(1'b1, 1'b0, 8'h77, 2'b00);
    repeat (300) tick();
    drive(1'b0, 1'b0, 8'h00, 2'b00);
    #1;
    check("t4_cnt_sat", cnt1[7:0], 255);
`endif
    clr = 2'b01;
    drive(1'b1, 1'b0, 8'h78, 2'b00);
    #1;
    check("t4_clr_not_yet", ovf1[0], 1);
    tick();
    clr = 2'b00;
    drive(1'b0, 1'b0, 8'h00, 2'b00);
    #1;
    check("t4_set_wins", ovf1, 2'b01);
    check("t4_lvl1_after_drop", lvl(lvl1, 0), 4);
`ifdef PORTGROUP_RX_OVFCNT_EN
    check("t4_cnt_clr_drop", cnt1[7:0], 1);
`endif

    // enable low for one cycle flushes, keeps overflow state
    drive(1'b0, 1'b0, 8'h00, 2'b01);
    tick();
    drive(1'b0, 1'b0, 8'h00, 2'b00);
    #1;
    check("t5_lvl0_3", lvl(lvl0, 0), 3);
    check("t5_lvl1_3", lvl(lvl1, 0), 3);
    check("t5_head1", head(data1, 0), 8'h55);
    ena = 1'b0;
    drive(1'b1, 1'b0, 8'h99, 2'b00);
    #1;
    check("t5_rdy0_dis", rdy0, 0);
    check("t5_rdy1_dis", rdy1, 0);
    tick();
    ena = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 2'b00);
    #1;
    check("t5_flush_lvl0", lvl(lvl0, 0), 0);
    check("t5_flush_lvl1", lvl(lvl1, 0), 0);
    check("t5_flush_head", head(data1, 0), 8'h00);
    check("t5_ovf_kept", ovf1, 2'b01);
`ifdef PORTGROUP_RX_OVFCNT_EN
    check("t5_cnt_kept", cnt1[7:0], 1);
`endif
    clr = 2'b01;
    tick();
    clr = 2'b00;
    #1;
    check("t5_ovf_cleared", ovf1, 2'b00);
`ifdef PORTGROUP_RX_OVFCNT_EN
    check("t5_cnt_cleared", cnt1[7:0], 0);
`endif

    // asynchronous reset mid-burst
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 8'h81 + 8'(i), 2'b00);
      tick();
    end
    drive(1'b1, 1'b0, 8'h83, 2'b00);
    #1;
    check("t6_lvl_pre", lvl(lvl0, 0), 2);
    rst = 1'b1;
    #1;
    check("t6_lvl0_async", lvl(lvl0, 0), 0);
    check("t6_data0_async", data0, 0);
    check("t6_lvl1_async", lvl1, 0);
    check("t6_rdy0_async", rdy0, 0);
    check("t6_rdy1_async", rdy1, 0);
    vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    drive(1'b1, 1'b0, 8'h90, 2'b00);
    #1;
    check("t6_head_before", head(data0, 0), 8'h00);
    tick();
    drive(1'b0, 1'b0, 8'h00, 2'b00);
    #1;
    check("t6_head0", head(data0, 0), 8'h90);
    check("t6_head1", head(data1, 0), 8'h90);
    check("t6_lvl", lvl(lvl0, 0), 1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
